// File: rtl/prm_pkg.sv
// rtl/prm_pkg.sv - shared types for the PRM edge scanner
package prm_pkg;
  localparam int IDX_W = 15;

  typedef logic [IDX_W-1:0] prm_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    FIN
  } scan_state_t;
endpackage

// File: rtl/prm_edge_scanner.sv
// rtl/prm_edge_scanner.sv - sweeps checker indices, packs edge_mask bits into streamed words
module prm_edge_scanner
  import prm_pkg::*;
#(
  parameter int IDX_W  = prm_pkg::IDX_W,
  parameter int CNT_W  = 16,
  parameter int WORD_W = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [IDX_W-1:0]                    base_idx,
  input  logic [CNT_W-1:0]                    count,
  output logic [IDX_W-1:0]                    chk_idx,
  input  logic                                chk_mask,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORD_W-1:0]                   out_data,
  output logic [CNT_W-$clog2(WORD_W)-1:0]     out_addr,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done,
  output logic [CNT_W-1:0]                    hit_cnt
);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int ADDR_W = CNT_W - BIT_W;

  scan_state_t        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   pos_q, pos_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]  word_q, word_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   hit_q, hit_d;

  logic [BIT_W-1:0]   bit_pos;
  logic               is_last;
  logic               word_end;
  logic               out_free;
  logic [WORD_W-1:0]  acc_next;

  assign bit_pos  = pos_q[BIT_W-1:0];
  assign is_last  = (pos_q == cnt_q - CNT_W'(1));
  assign word_end = (bit_pos == BIT_W'(WORD_W - 1)) || is_last;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    acc_next          = acc_q;
    acc_next[bit_pos] = chk_mask;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    word_d      = word_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    hit_d       = hit_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = base_idx;
          cnt_d   = count;
          pos_d   = '0;
          acc_d   = '0;
          word_d  = '0;
          hit_d   = '0;
          busy_d  = 1'b1;
          // An empty sweep passes through DRAIN (nothing pending) so done lands in cycle 2.
          state_d = (count == '0) ? DRAIN : SCAN;
        end
      end
      SCAN: begin
        // A completed word that cannot be handed off holds the index; the sample repeats next cycle.
        if (!(word_end && !out_free)) begin
          hit_d = hit_q + {{(CNT_W-1){1'b0}}, chk_mask};
          idx_d = idx_q + IDX_W'(1);
          pos_d = pos_q + CNT_W'(1);
          if (word_end) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_next;
            out_addr_d  = word_q;
            out_last_d  = is_last;
            word_d      = word_q + ADDR_W'(1);
            acc_d       = '0;
          end else begin
            acc_d = acc_next;
          end
          if (is_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_free) begin
          state_d = FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pos_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hit_q       <= hit_d;
    end
  end

  assign chk_idx   = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit_cnt   = hit_q;
endmodule

// File: tb/tb_prm_edge_scanner.sv
// tb/tb_prm_edge_scanner.sv - directed and randomized sweeps against a behavioural checker model
module tb_prm_edge_scanner;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [14:0] base_idx;
  logic [15:0] count;
  logic [14:0] chk_idx;
  logic        chk_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [10:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [15:0] hit_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int mode    = 0;
  logic        mask_tab [0:32767];
  logic [31:0] exp_w    [0:1023];
  logic [14:0] idx_trace[$];

  always #5 clk = ~clk;

  prm_edge_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_idx(base_idx), .count(count),
    .chk_idx(chk_idx), .chk_mask(chk_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last), .busy(busy),
    .done(done), .hit_cnt(hit_cnt)
  );

  // Stand-in for the combinational obstacle checker.
  assign chk_mask = (mode == 0) ? (chk_idx[0] ^ chk_idx[1]) :
                    (mode == 1) ? 1'b1 : mask_tab[chk_idx];

  function automatic int model_mask(input int idx);
    if (mode == 0) return ((idx % 2) + ((idx / 2) % 2)) % 2;
    if (mode == 1) return 1;
    return int'(mask_tab[idx]);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // rmode: 0 ready always high, 1 hold ready low 50 cycles after first valid, 2 random ready
  task automatic run_sweep(input int base, input int cnt, input int rmode, input bit poke, input string tag);
    int nw, exp_hits, words, cyc, done_cyc, stall_left, pop, budget, idx;
    bit stable_ok, any_valid, prev_v, prev_hs;
    logic [31:0] prev_d, w;
    logic [10:0] prev_a;
    logic prev_l;
    nw = (cnt + 31) / 32;
    exp_hits = 0;
    for (int i = 0; i < 1024; i++) exp_w[i] = '0;
    for (int p = 0; p < cnt; p++) begin
      idx = (base + p) % 32768;
      if (model_mask(idx) == 1) begin
        w = exp_w[p / 32];
        w = w | (32'd1 << (p % 32));
        exp_w[p / 32] = w;
        exp_hits++;
      end
    end
    words = 0; done_cyc = -1; stall_left = -1; pop = 0;
    stable_ok = 1; any_valid = 0; prev_v = 0; prev_hs = 0;
    prev_d = '0; prev_a = '0; prev_l = 0;
    budget = 3 * cnt + 200;
    idx_trace.delete();

    @(posedge clk); #1;
    start = 1; base_idx = base[14:0]; count = cnt[15:0]; out_ready = 1;
    @(posedge clk); #1;
    start = 0; cyc = 1;
    check({tag, ".busy1"}, busy, 1);
    check({tag, ".idx1"}, chk_idx, base[14:0]);
    while (cyc < budget) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc <= cnt) idx_trace.push_back(chk_idx);
      if (poke && cyc == 5) begin
        start = 1; base_idx = ~base[14:0]; count = 16'd3;
      end else begin
        start = 0;
      end
      case (rmode)
        1: begin
          if (out_valid && stall_left < 0) stall_left = 50;
          if (stall_left > 0) begin
            out_ready = 0;
            stall_left--;
            if (stall_left == 0) check({tag, ".frozen_idx"}, chk_idx, 15'((base + 63) % 32768));
          end else begin
            out_ready = 1;
          end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1;
      endcase
      if (prev_v && !prev_hs &&
          !(out_valid && out_data === prev_d && out_addr === prev_a && out_last === prev_l))
        stable_ok = 0;
      prev_v = out_valid; prev_hs = out_valid && out_ready;
      prev_d = out_data; prev_a = out_addr; prev_l = out_last;
      if (out_valid) any_valid = 1;
      if (out_valid && out_ready) begin
        check({tag, ".data"}, out_data, (words < 1024) ? exp_w[words] : 32'hx);
        check({tag, ".addr"}, out_addr, 11'(words));
        check({tag, ".last"}, out_last, (words == nw - 1) ? 1 : 0);
        pop += $countones(out_data);
        words++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 0; out_ready = 1;
    check({tag, ".done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
    if (rmode == 0) check({tag, ".done_cycle"}, done_cyc, cnt + 2);
    check({tag, ".hit_cnt"}, hit_cnt, exp_hits);
    check({tag, ".words"}, words, nw);
    check({tag, ".any_valid"}, any_valid, (nw > 0) ? 1 : 0);
    check({tag, ".stable"}, stable_ok, 1);
    check({tag, ".popcount"}, pop, exp_hits);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".hit_hold"}, hit_cnt, exp_hits);
  endtask

  initial begin
    rst_n = 0; start = 0; base_idx = '0; count = '0; out_ready = 1;
    for (int i = 0; i < 32768; i++) mask_tab[i] = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    check("reset.a", {chk_idx, out_valid, out_addr, out_last, busy, done, hit_cnt}, 64'd0);
    check("reset.data", out_data, 32'd0);
    rst_n = 1;

    mode = 0; run_sweep(0, 32, 0, 0, "basic");
    check("basic.word", exp_w[0], 32'h66666666);
    mode = 1; run_sweep(5, 40, 0, 0, "partial");
    check("partial.w1", exp_w[1], 32'h000000FF);
    mode = 2; run_sweep(1234, 96, 1, 0, "backpressure");
    mode = 0; run_sweep(32'h7FFE, 4, 0, 0, "wrap");
    check("wrap.n", idx_trace.size(), 4);
    if (idx_trace.size() == 4) begin
      check("wrap.i0", idx_trace[0], 15'h7FFE);
      check("wrap.i1", idx_trace[1], 15'h7FFF);
      check("wrap.i2", idx_trace[2], 15'h0000);
      check("wrap.i3", idx_trace[3], 15'h0001);
    end
    run_sweep(32'h7FFF, 2, 0, 0, "wrap2");
    run_sweep(77, 0, 0, 0, "empty");
    mode = 2; run_sweep(300, 70, 0, 1, "poke");

    @(posedge clk); #1;
    start = 1; base_idx = 15'd100; count = 16'd200;
    @(posedge clk); #1;
    start = 0;
    repeat (40) @(posedge clk);
    #3; rst_n = 0; #1;
    check("abort.a", {chk_idx, out_valid, out_addr, out_last, busy, done, hit_cnt}, 64'd0);
    check("abort.data", out_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort.nodone", done, 0);
    end
    rst_n = 1;
    run_sweep(100, 200, 0, 0, "after_abort");

    for (int r = 0; r < 3; r++)
      run_sweep($urandom_range(0, 32767), $urandom_range(1, 100), 2, 0, "random");

    run_sweep(0, 32768, 0, 0, "full");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
